// File: rtl/alu_pool_pkg.sv
// Shared definitions for the redundant ALU pool.
// Contents:
//   ALU_* opcode constants for the 3-bit alu_ctrl field
//   pool_state_t     state encoding for the pool controller
//   mod3()           residue of a value modulo 3 (up to 64 bits)
package alu_pool_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [1:0] {
        POOL_OK        = 2'd0,
        POOL_RETRY     = 2'd1,
        POOL_EXHAUSTED = 2'd2
    } pool_state_t;

    // 4 == 1 (mod 3), so the residue is the sum of the base-4 digits,
    // folded back below 3 after every digit.
    function automatic logic [1:0] mod3(input logic [63:0] x);
        logic [2:0] acc;
        acc = 3'd0;
        for (int i = 0; i < 32; i++) begin
            acc = acc + {1'b0, x[2*i +: 2]};
            if (acc >= 3'd3) acc = acc - 3'd3;
        end
        return acc[1:0];
    endfunction

endpackage

// File: rtl/alu_lane.sv
// One ALU lane with carry-out, fault injection and a mod-3 residue checker.
// Ports:
//   ctrl    in   3       operation select (see alu_pool_pkg)
//   a, b    in   DATA_W  operands
//   inject  in   1       flips bit 0 of the result after the carry is formed
//   result  out  DATA_W  lane result (including any injected flip)
//   zero    out  1       result equals zero
//   err     out  1       residue mismatch on ADD/SUB (not qualified by valid)
module alu_lane
    import alu_pool_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        ctrl,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              inject,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              err
);

    logic              is_sub;
    logic              checked;
    logic [DATA_W-1:0] b_op;
    logic [DATA_W:0]   sum;
    logic              cout;
    logic [DATA_W-1:0] raw;
    logic [1:0]        ra;
    logic [1:0]        rb;
    logic [1:0]        rr;
    logic [3:0]        lhs;
    logic [3:0]        rhs;

    always_comb begin
        is_sub  = (ctrl == ALU_SUB);
        checked = (ctrl == ALU_ADD) || is_sub;
        b_op    = is_sub ? ~b : b;
        sum     = {1'b0, a} + {1'b0, b_op} + (DATA_W+1)'(is_sub);
        cout    = sum[DATA_W];
        case (ctrl)
            ALU_ADD, ALU_SUB: raw = sum[DATA_W-1:0];
            ALU_AND:          raw = a & b;
            ALU_OR:           raw = a | b;
            ALU_SLT:          raw = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            default:          raw = '0;
        endcase
        result = raw ^ {{(DATA_W-1){1'b0}}, inject};
        zero   = (result == '0);
    end

    // With DATA_W even, 2^DATA_W == 1 (mod 3), so the carry-out contributes
    // exactly 1 to the residue of the full sum, and ~B == -B (mod 3).
    always_comb begin
        ra  = mod3(64'(a));
        rb  = mod3(64'(b));
        rr  = mod3(64'(result));
        lhs = is_sub ? (4'(ra) + 4'd3 - 4'(rb) + 4'd1) : (4'(ra) + 4'(rb));
        rhs = 4'(rr) + 4'(cout);
        err = checked && (mod3(64'(lhs)) != mod3(64'(rhs)));
    end

endmodule

// File: rtl/alu_spare_pool.sv
// N-lane redundant ALU with residue checking, replay on error and lane
// retirement after FAULT_THRESH consecutive errors. Result registered at EX/MEM.
// Optional feature macro: ALU_POOL_STATS_EN (per-lane error counters and
// stat_sel/stat_cnt read port).
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   valid_e              operation present
//   alu_ctrl_e           opcode
//   src_a_e, src_b_e     operands
//   force_fault_e        per-lane fault injection
//   stall_e              hold upstream inputs next cycle (combinational)
//   zero_e               active lane result is zero (combinational)
//   valid_m/alu_result_m registered result
//   active_unit          lane in use
//   failed_mask          sticky retired lanes
//   hardware_fault_flag  sticky, first retirement seen
//   alu_exhausted        sticky, all lanes retired
//
// State table:
//   POOL_OK        | no outstanding error on the active lane
//   POOL_RETRY     | replaying after err_cnt consecutive errors
//   POOL_EXHAUSTED | all lanes retired, checks ignored, ops pass through
module alu_spare_pool
    import alu_pool_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int NUM_UNITS    = 3,
    parameter int FAULT_THRESH = 2,
    localparam int AW          = $clog2(NUM_UNITS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_e,
    input  logic [2:0]           alu_ctrl_e,
    input  logic [DATA_W-1:0]    src_a_e,
    input  logic [DATA_W-1:0]    src_b_e,
    input  logic [NUM_UNITS-1:0] force_fault_e,
    output logic                 stall_e,
    output logic                 zero_e,
    output logic                 valid_m,
    output logic [DATA_W-1:0]    alu_result_m,
    output logic [AW-1:0]        active_unit,
    output logic [NUM_UNITS-1:0] failed_mask,
    output logic                 hardware_fault_flag,
    output logic                 alu_exhausted
`ifdef ALU_POOL_STATS_EN
    ,
    input  logic [AW-1:0]        stat_sel,
    output logic [15:0]          stat_cnt
`endif
);

    logic [DATA_W-1:0]    lane_res [NUM_UNITS];
    logic [NUM_UNITS-1:0] lane_zero;
    logic [NUM_UNITS-1:0] lane_chk;

    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_lane
        alu_lane #(.DATA_W(DATA_W)) u_lane (
            .ctrl   (alu_ctrl_e),
            .a      (src_a_e),
            .b      (src_b_e),
            .inject (force_fault_e[g]),
            .result (lane_res[g]),
            .zero   (lane_zero[g]),
            .err    (lane_chk[g])
        );
    end

    pool_state_t state, state_nxt;
    logic [3:0]    err_cnt;
    logic          raw_err;
    logic          lane_err;
    logic          at_thresh;
    logic          retire;
    logic          capture;
    logic [AW-1:0] cand;
    logic [AW-1:0] nxt_unit;
    logic          nxt_found;

    assign zero_e = lane_zero[active_unit];

    always_comb begin
        raw_err   = valid_e && lane_chk[active_unit];
        lane_err  = raw_err && (state != POOL_EXHAUSTED);
        at_thresh = (({1'b0, err_cnt} + 5'd1) == 5'(FAULT_THRESH));
        retire    = lane_err && at_thresh;
    end

    // Next healthy lane above the current one, wrapping through index 0.
    always_comb begin
        cand      = active_unit;
        nxt_unit  = active_unit;
        nxt_found = 1'b0;
        for (int k = 1; k < NUM_UNITS; k++) begin
            cand = AW'((int'(active_unit) + k) % NUM_UNITS);
            if (!nxt_found && !failed_mask[cand]) begin
                nxt_found = 1'b1;
                nxt_unit  = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= POOL_OK;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            POOL_OK, POOL_RETRY: begin
                if (valid_e) begin
                    if (retire)        state_nxt = nxt_found ? POOL_OK : POOL_EXHAUSTED;
                    else if (lane_err) state_nxt = POOL_RETRY;
                    else               state_nxt = POOL_OK;
                end
            end
            POOL_EXHAUSTED: state_nxt = POOL_EXHAUSTED;
            default:        state_nxt = POOL_OK;
        endcase
    end

    // Gating with rst keeps stall_e low while reset is held even if inputs
    // still present a faulty operation.
    always_comb begin
        stall_e = lane_err && rst;
        capture = valid_e && !lane_err;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt             <= '0;
            active_unit         <= '0;
            failed_mask         <= '0;
            hardware_fault_flag <= 1'b0;
            alu_exhausted       <= 1'b0;
            valid_m             <= 1'b0;
            alu_result_m        <= '0;
        end else begin
            valid_m <= capture;
            if (capture) begin
                alu_result_m <= lane_res[active_unit];
                err_cnt      <= '0;
            end
            if (retire) begin
                err_cnt                  <= '0;
                failed_mask[active_unit] <= 1'b1;
                hardware_fault_flag      <= 1'b1;
                if (nxt_found) active_unit   <= nxt_unit;
                else           alu_exhausted <= 1'b1;
            end else if (lane_err) begin
                err_cnt <= err_cnt + 4'd1;
            end
        end
    end

`ifdef ALU_POOL_STATS_EN
    logic [15:0] stat_q [NUM_UNITS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_UNITS; i++) stat_q[i] <= '0;
            stat_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (raw_err && (active_unit == AW'(i)) && (stat_q[i] != 16'hFFFF))
                    stat_q[i] <= stat_q[i] + 16'd1;
            end
            stat_cnt <= stat_q[stat_sel];
        end
    end
`endif

endmodule

// File: tb/tb_alu_spare_pool.sv
module tb_alu_spare_pool;
    import alu_pool_pkg::*;

    localparam int DATA_W = 32;
    localparam int NU     = 3;
    localparam int FT     = 2;
    localparam int AW     = $clog2(NU);

    logic              clk;
    logic              rst;
    logic              valid_e;
    logic [2:0]        alu_ctrl_e;
    logic [DATA_W-1:0] src_a_e;
    logic [DATA_W-1:0] src_b_e;
    logic [NU-1:0]     force_fault_e;
    logic              stall_e;
    logic              zero_e;
    logic              valid_m;
    logic [DATA_W-1:0] alu_result_m;
    logic [AW-1:0]     active_unit;
    logic [NU-1:0]     failed_mask;
    logic              hardware_fault_flag;
    logic              alu_exhausted;
`ifdef ALU_POOL_STATS_EN
    logic [AW-1:0]     stat_sel;
    logic [15:0]       stat_cnt;
`endif

    alu_spare_pool #(.DATA_W(DATA_W), .NUM_UNITS(NU), .FAULT_THRESH(FT)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .valid_e             (valid_e),
        .alu_ctrl_e          (alu_ctrl_e),
        .src_a_e             (src_a_e),
        .src_b_e             (src_b_e),
        .force_fault_e       (force_fault_e),
        .stall_e             (stall_e),
        .zero_e              (zero_e),
        .valid_m             (valid_m),
        .alu_result_m        (alu_result_m),
        .active_unit         (active_unit),
        .failed_mask         (failed_mask),
        .hardware_fault_flag (hardware_fault_flag),
        .alu_exhausted       (alu_exhausted)
`ifdef ALU_POOL_STATS_EN
        ,
        .stat_sel            (stat_sel),
        .stat_cnt            (stat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [DATA_W-1:0] exp_q [$];

    // control-plane reference model
    int          m_active;
    logic [NU-1:0] m_failed;
    int          m_err;
    int          m_state;   // 0 ok, 1 retry, 2 exhausted
    bit          m_hw;
    bit          m_exh;

    typedef struct {
        logic [2:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] res;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_failed = '0; m_err = 0; m_state = 0; m_hw = 0; m_exh = 0;
        exp_q.delete();
    endtask

    function automatic bit model_det();
        return valid_e && (alu_ctrl_e == ALU_ADD || alu_ctrl_e == ALU_SUB)
               && force_fault_e[m_active] && (m_state != 2);
    endfunction

    task automatic model_update(input bit det);
        int nxt;
        if (!valid_e || m_state == 2) return;
        if (!det) begin
            m_err = 0; m_state = 0;
        end else if (m_err + 1 == FT) begin
            m_failed[m_active] = 1'b1;
            m_hw  = 1;
            m_err = 0;
            nxt   = -1;
            for (int k = 1; k < NU; k++)
                if (nxt < 0 && !m_failed[(m_active + k) % NU]) nxt = (m_active + k) % NU;
            if (nxt < 0) begin
                m_exh = 1; m_state = 2;
            end else begin
                m_active = nxt; m_state = 0;
            end
        end else begin
            m_err++; m_state = 1;
        end
    endtask

    task automatic chk_status();
        chk("active_unit", 64'(active_unit), 64'(m_active));
        chk("failed_mask", 64'(failed_mask), 64'(m_failed));
        chk("hw_fault_flag", 64'(hardware_fault_flag), 64'(m_hw));
        chk("alu_exhausted", 64'(alu_exhausted), 64'(m_exh));
    endtask

    // Drive one op, hold it through stalls, check stall count and result.
    task automatic do_op(input string name, input logic [2:0] op,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input logic [NU-1:0] frc, input bit pulse,
                         input logic [DATA_W-1:0] exp, input int exp_stalls);
        bit det;
        bit done;
        int nst;
        valid_e = 1'b1; alu_ctrl_e = op; src_a_e = a; src_b_e = b; force_fault_e = frc;
        done = 0; nst = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            det = model_det();
            chk({name, " stall_e"}, 64'(stall_e), 64'(det));
            if (!det) begin
                chk({name, " zero_e"}, 64'(zero_e), 64'(exp == '0));
                exp_q.push_back(exp);
            end
            @(posedge clk); #1;
            model_update(det);
            chk({name, " valid_m"}, 64'(valid_m), 64'(!det));
            if (valid_m) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL %s unexpected valid_m result=%0h", name, alu_result_m);
                end else begin
                    chk({name, " result"}, 64'(alu_result_m), 64'(exp_q.pop_front()));
                end
            end
            chk_status();
            if (det) nst++;
            else     done = 1;
            if (pulse) force_fault_e = '0;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL %s timeout waiting for capture stalls=%0d", name, nst);
        end
        chk({name, " stalls"}, 64'(nst), 64'(exp_stalls));
        valid_e = 1'b0;
        force_fault_e = '0;
        @(posedge clk); #1;
        chk({name, " idle valid_m"}, 64'(valid_m), 64'd0);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, " valid_m"}, 64'(valid_m), 64'd0);
        chk({name, " result"}, 64'(alu_result_m), 64'd0);
        chk({name, " active"}, 64'(active_unit), 64'd0);
        chk({name, " failed"}, 64'(failed_mask), 64'd0);
        chk({name, " hw"}, 64'(hardware_fault_flag), 64'd0);
        chk({name, " exh"}, 64'(alu_exhausted), 64'd0);
        chk({name, " stall_e"}, 64'(stall_e), 64'd0);
    endtask

    vec_t vecs [11];

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{ALU_ADD, 32'd5,          32'd7,          32'd12};
        vecs[1]  = '{ALU_SUB, 32'd10,         32'd3,          32'd7};
        vecs[2]  = '{ALU_SUB, 32'd3,          32'd10,         32'hFFFF_FFF9};
        vecs[3]  = '{ALU_AND, 32'hF0,         32'h3C,         32'h30};
        vecs[4]  = '{ALU_OR,  32'hF0,         32'h0F,         32'hFF};
        vecs[5]  = '{ALU_SLT, 32'hFFFF_FFFF,  32'd1,          32'd1};
        vecs[6]  = '{ALU_SLT, 32'd1,          32'hFFFF_FFFF,  32'd0};
        vecs[7]  = '{3'b100,  32'd9,          32'd9,          32'd0};
        vecs[8]  = '{3'b111,  32'h1234,       32'h5678,       32'd0};
        vecs[9]  = '{ALU_ADD, 32'hFFFF_FFFF,  32'd1,          32'd0};
        vecs[10] = '{ALU_SUB, 32'd5,          32'd5,          32'd0};

        rst = 1'b0; valid_e = 1'b0; alu_ctrl_e = '0; src_a_e = '0; src_b_e = '0;
        force_fault_e = '0;
`ifdef ALU_POOL_STATS_EN
        stat_sel = '0;
`endif
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        chk_reset_vals("reset");
        rst = 1'b1;

        for (int i = 0; i < 11; i++)
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, '0, 0, vecs[i].res, 0);

        // single-cycle fault: one replay, no retirement
        do_op("pulse_fault", ALU_ADD, 32'd5, 32'd7, 3'b001, 1, 32'd12, 1);
        // persistent fault on lane 0: retire it, result from lane 1
        do_op("retire_lane0", ALU_SUB, 32'd10, 32'd3, 3'b001, 0, 32'd7, 2);
        // unchecked op: injection reaches the result but never stalls
        do_op("and_unchecked", ALU_AND, 32'hF0, 32'h3C, 3'b111, 0, 32'h31, 0);

        // reset while in RETRY
        valid_e = 1'b1; alu_ctrl_e = ALU_ADD; src_a_e = 32'd2; src_b_e = 32'd2;
        force_fault_e = 3'b010;
        @(negedge clk);
        chk("pre_reset stall_e", 64'(stall_e), 64'd1);
        @(posedge clk); #1;
        chk("pre_reset valid_m", 64'(valid_m), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_vals("mid_retry_reset");
        valid_e = 1'b0; force_fault_e = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        do_op("after_reset", ALU_ADD, 32'd2, 32'd2, 3'b000, 0, 32'd4, 0);

        // all lanes faulty: six stalls, then pass-through with injected flip
        do_op("exhaust", ALU_ADD, 32'd5, 32'd7, 3'b111, 0, 32'd13, 6);
        do_op("exhausted_add", ALU_ADD, 32'd1, 32'd1, 3'b111, 0, 32'd3, 0);
        do_op("exhausted_clean", ALU_ADD, 32'd20, 32'd22, 3'b000, 0, 32'd42, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
